sr_bank_sched: RTL and testbench
================================

# sr_bank_sched

Command scheduler for a bank of master-slave SR flip-flops. It takes set/reset/toggle requests from several requesters over a valid/ready handshake. Round-robin arbitration admits one request at a time, and the block drives the bank's per-bit S/R lines as single-cycle pulses. S and R are never asserted together on any bit, and the bank is given a settle cycle after each command before the next one issues.

## Interface
Parameters:
- NREQ, 4, number of requesters (≥2)
- NBITS, 8, flip-flops in the bank
- IDX_W, $clog2(NBITS), bit-index width

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- REQ_VALID  in  NREQ  request pending, one bit per requester
- REQ_OP  in  2*NREQ  op per requester: 00 nop, 01 set, 10 reset, 11 toggle
- REQ_IDX  in  IDX_W*NREQ  target bit per requester
- REQ_READY  out  NREQ  one-hot grant; transfer occurs when VALID&READY
- CLR_ALL  in  1  clear-all request, priority over REQ_VALID
- Q  in  NBITS  bank state feedback
- S  out  NBITS  set pulses to bank
- R  out  NBITS  reset pulses to bank
- BUSY  out  1  high in ISSUE and SETTLE
- DONE  out  1  one-cycle pulse as a command retires
- GRANT_ID  out  $clog2(NREQ)  requester of the command in flight

## Operation
- States: IDLE, ISSUE, SETTLE.
- IDLE:
  - CLR_ALL=1 → latch the clear command; REQ_READY stays all-0; go to ISSUE.
  - Otherwise, if any REQ_VALID → winner = first valid index at or after PTR, cyclically. REQ_READY[winner]=1 combinationally in the same cycle. Latch op, idx and id. PTR←(winner+1) mod NREQ. Go to ISSUE.
  - No request → stay in IDLE, PTR unchanged.
- ISSUE (1 cycle), registered outputs:
  - set: S[idx]=1.
  - reset: R[idx]=1.
  - toggle: sample Q[idx] on entry to ISSUE; if it is 1 drive R[idx]=1, else S[idx]=1.
  - nop: no pulse.
  - clear: R=all-1, S=0.
  - Then go to SETTLE.
- SETTLE (1 cycle): S=R=0, DONE=1, then go to IDLE.
- Invariants:
  - (S & R)==0 in every cycle.
  - Outside a clear, at most one bit of S|R is set.
  - REQ_READY is zero outside IDLE and is never multi-hot.
- GRANT_ID holds from ISSUE through SETTLE. It is 0 for clear.
- Out-of-range REQ_IDX (≥NBITS): command accepted as nop; DONE still pulses.

## Timing
- Accept in cycle N → S/R pulse in N+1 → DONE in N+2 → next accept possible in N+3. Throughput is 1 command per 3 cycles.
- Requests arriving while BUSY wait; valid must be held until ready.
- CLR_ALL and REQ_VALID in the same IDLE cycle: clear wins, the request stays pending, PTR unchanged.
- PTR wrap: with PTR=NREQ-1 and only requester 0 valid, requester 0 wins and PTR becomes 1.
- Reset values, on the edge where RST=1:
  - state=IDLE, PTR=0
  - S=0, R=0
  - REQ_READY=0 (combinationally forced while RST=1)
  - BUSY=0, DONE=0, GRANT_ID=0
- Reset mid-ISSUE or mid-SETTLE aborts the command: no DONE, pulses drop at that edge.

## Structure
- sr_sched_pkg:
  - op encoding constants: OP_NOP, OP_SET, OP_RST, OP_TGL
  - state enum
  - internal CMD_CLR code
- Sub-module rr_arbiter: combinational round-robin pick from (valid vector, PTR) to one-hot grant plus index. PTR register stays in the parent.

## Test plan
- Reset, then requester 2 set idx 5 → READY[2] in accept cycle; S=8'h20 one cycle later; DONE next; R=0 throughout.
- All 4 requesters valid continuously, PTR=0 → grant order 0,1,2,3,0 with accepts 3 cycles apart.
- Q[3]=1, toggle idx 3 → R=8'h08, S=0; then with Q[3]=0, toggle idx 3 → S=8'h08.
- CLR_ALL and REQ_VALID[1] together in IDLE → R=8'hFF, READY stays 0; requester 1 is granted in the next IDLE cycle.
- RST asserted in ISSUE of a set → S=0 at that edge, no DONE, state IDLE, PTR=0.
- Every cycle: assert (S&R)==0 and $onehot0(REQ_READY).

Source files
------------

// File: rtl/sr_sched_pkg.sv
// Shared definitions for the SR flip-flop bank command scheduler.
//   - request op encodings (OP_*) as seen on REQ_OP
//   - internal command codes (CMD_*), a superset of the ops with a clear-all code
//   - scheduler state enum
package sr_sched_pkg;

   localparam logic [1:0] OP_NOP = 2'b00;
   localparam logic [1:0] OP_SET = 2'b01;
   localparam logic [1:0] OP_RST = 2'b10;
   localparam logic [1:0] OP_TGL = 2'b11;

   // Internal commands: the four request ops plus clear-all, which has no
   // requester encoding of its own.
   localparam logic [2:0] CMD_NOP = 3'b000;
   localparam logic [2:0] CMD_SET = 3'b001;
   localparam logic [2:0] CMD_RST = 3'b010;
   localparam logic [2:0] CMD_TGL = 3'b011;
   localparam logic [2:0] CMD_CLR = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_SETTLE = 2'd2
   } state_e;

   function automatic logic [2:0] op2cmd(input logic [1:0] op);
      return {1'b0, op};
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   valid_i : request vector
//   ptr_i   : highest-priority index this cycle (register kept by the parent)
//   gnt_o   : one-hot grant, zero when nothing is valid
//   idx_o   : binary index of the granted requester
//   any_o   : at least one request is valid
module rr_arbiter #(
   parameter int NREQ = 4,
   localparam int PW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] valid_i,
   input  logic [PW-1:0]   ptr_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [PW-1:0]   idx_o,
   output logic            any_o
);

   // Scan cyclically from ptr_i; the first valid entry wins.
   always_comb begin
      int j;
      j     = 0;
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         j = (int'(ptr_i) + i) % NREQ;
         if (!any_o && valid_i[j]) begin
            any_o    = 1'b1;
            gnt_o[j] = 1'b1;
            idx_o    = PW'(j);
         end
      end
   end

endmodule

// File: rtl/sr_bank_sched.sv
// Command scheduler for a bank of master-slave SR flip-flops.
// Requesters post set/reset/toggle commands over valid/ready; one command is
// admitted at a time by round-robin, issued as a single-cycle S/R pulse, then
// the bank gets a settle cycle before the next admission (1 cmd / 3 cycles).
// Ports:
//   CLK, RST          : clock, synchronous active-high reset
//   REQ_VALID/OP/IDX  : per-requester request, op and target bit
//   REQ_READY         : one-hot grant (only in IDLE, forced low during RST)
//   CLR_ALL           : clear-all request, beats requesters in IDLE
//   Q                 : bank state feedback (used by toggle)
//   S, R              : registered set/reset pulses to the bank
//   BUSY, DONE        : command in flight / command retiring
//   GRANT_ID          : requester of the command in flight (0 for clear)
module sr_bank_sched #(
   parameter int NREQ  = 4,
   parameter int NBITS = 8,
   parameter int IDX_W = $clog2(NBITS)
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [NREQ-1:0]          REQ_VALID,
   input  logic [2*NREQ-1:0]        REQ_OP,
   input  logic [IDX_W*NREQ-1:0]    REQ_IDX,
   output logic [NREQ-1:0]          REQ_READY,
   input  logic                     CLR_ALL,
   input  logic [NBITS-1:0]         Q,
   output logic [NBITS-1:0]         S,
   output logic [NBITS-1:0]         R,
   output logic                     BUSY,
   output logic                     DONE,
   output logic [$clog2(NREQ)-1:0]  GRANT_ID
);
   import sr_sched_pkg::*;

   localparam int ID_W = $clog2(NREQ);

   state_e            state_q, state_d;
   logic [ID_W-1:0]   ptr_q, ptr_nxt;
   logic [ID_W-1:0]   id_q;
   logic [NBITS-1:0]  s_q, r_q, s_d, r_d;

   logic [NREQ-1:0]   gnt;
   logic [ID_W-1:0]   win;
   logic              any_vld;
   logic              accept;

   logic [1:0]        sel_op;
   logic [IDX_W-1:0]  sel_idx;
   logic [NBITS-1:0]  bit_oh;
   logic              q_bit;
   logic [2:0]        cmd;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .valid_i (REQ_VALID),
      .ptr_i   (ptr_q),
      .gnt_o   (gnt),
      .idx_o   (win),
      .any_o   (any_vld)
   );

   // Decode the winner's command into the pulse pattern for the ISSUE cycle.
   always_comb begin
      sel_op  = REQ_OP[int'(win)*2 +: 2];
      sel_idx = REQ_IDX[int'(win)*IDX_W +: IDX_W];
      // Out-of-range index yields an empty mask, so the command degrades to nop.
      bit_oh  = (int'(sel_idx) < NBITS) ? (NBITS'(1) << sel_idx) : '0;
      q_bit   = |(Q & bit_oh);
      cmd     = CLR_ALL ? CMD_CLR : op2cmd(sel_op);
      s_d     = '0;
      r_d     = '0;
      case (cmd)
         CMD_SET: s_d = bit_oh;
         CMD_RST: r_d = bit_oh;
         CMD_TGL: begin
            if (q_bit) r_d = bit_oh;
            else       s_d = bit_oh;
         end
         CMD_CLR: r_d = '1;
         default: ;
      endcase
      ptr_nxt = (int'(win) == NREQ-1) ? '0 : win + 1'b1;
   end

   assign accept = (state_q == ST_IDLE) && (CLR_ALL || any_vld);

   // FSM: state register
   always_ff @(posedge CLK) begin
      if (RST) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (CLR_ALL || any_vld) state_d = ST_ISSUE;
         ST_ISSUE:  state_d = ST_SETTLE;
         ST_SETTLE: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // FSM: outputs. A pending clear holds off every grant so the request stays
   // pending for a later IDLE cycle.
   always_comb begin
      REQ_READY = '0;
      BUSY      = (state_q != ST_IDLE);
      DONE      = (state_q == ST_SETTLE);
      if (state_q == ST_IDLE && !RST && !CLR_ALL) REQ_READY = gnt;
   end

   // Datapath: pulses are latched on admission so they appear exactly in ISSUE.
   always_ff @(posedge CLK) begin
      if (RST) begin
         ptr_q <= '0;
         id_q  <= '0;
         s_q   <= '0;
         r_q   <= '0;
      end else if (accept) begin
         s_q  <= s_d;
         r_q  <= r_d;
         id_q <= CLR_ALL ? '0 : win;
         if (!CLR_ALL) ptr_q <= ptr_nxt;
      end else if (state_q == ST_ISSUE) begin
         s_q <= '0;
         r_q <= '0;
      end
   end

   assign S        = s_q;
   assign R        = r_q;
   assign GRANT_ID = id_q;

endmodule

// File: tb/tb_sr_bank_sched.sv
module tb_sr_bank_sched;

   localparam int NREQ = 4, NBITS = 8, IDX_W = 3;

   logic        CLK = 1'b0;
   logic        RST;
   logic [3:0]  REQ_VALID, REQ_READY;
   logic [7:0]  REQ_OP;
   logic [11:0] REQ_IDX;
   logic        CLR_ALL;
   logic [7:0]  Q, S, R;
   logic        BUSY, DONE;
   logic [1:0]  GRANT_ID;

   // second instance with a 6-bit bank so indices 6/7 are out of range
   logic [3:0]  v6, rdy6, v6_n;
   logic [7:0]  op6, op6_n;
   logic [11:0] idx6, idx6_n;
   logic [5:0]  S6, R6;
   logic        busy6, done6;
   logic [1:0]  gid6;

   always #5 CLK = ~CLK;

   sr_bank_sched #(.NREQ(NREQ), .NBITS(NBITS), .IDX_W(IDX_W)) u_dut (
      .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_OP(REQ_OP),
      .REQ_IDX(REQ_IDX), .REQ_READY(REQ_READY), .CLR_ALL(CLR_ALL), .Q(Q),
      .S(S), .R(R), .BUSY(BUSY), .DONE(DONE), .GRANT_ID(GRANT_ID));

   sr_bank_sched #(.NREQ(4), .NBITS(6), .IDX_W(3)) u_dut6 (
      .CLK(CLK), .RST(RST), .REQ_VALID(v6), .REQ_OP(op6),
      .REQ_IDX(idx6), .REQ_READY(rdy6), .CLR_ALL(1'b0), .Q(6'h00),
      .S(S6), .R(R6), .BUSY(busy6), .DONE(done6), .GRANT_ID(gid6));

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // phase: 0 idle, 1 pulse cycle, 2 settle cycle
   int         m_phase, m_ptr, m_id;
   logic [7:0] m_S, m_R;
   logic [3:0] m_rdy;

   function automatic int pick(input logic [3:0] v, input int p);
      for (int k = 0; k < 4; k++)
         if (v[(p + k) % 4]) return (p + k) % 4;
      return -1;
   endfunction

   task automatic m_reset();
      m_phase = 0; m_ptr = 0; m_id = 0; m_S = 0; m_R = 0;
   endtask

   // Drive one cycle of inputs at the falling edge, then check the DUT outputs.
   task automatic drive_chk(input logic rst, input logic clr, input logic [3:0] v,
                            input logic [7:0] op, input logic [11:0] idx, input logic [7:0] q);
      int w;
      @(negedge CLK);
      RST = rst; CLR_ALL = clr; REQ_VALID = v; REQ_OP = op; REQ_IDX = idx; Q = q;
      v6 = v6_n; op6 = op6_n; idx6 = idx6_n;
      #1;
      m_rdy = '0;
      if (m_phase == 0 && !rst && !clr) begin
         w = pick(v, m_ptr);
         if (w >= 0) m_rdy[w] = 1'b1;
      end
      chk("ready", REQ_READY, m_rdy);
      chk("S", S, m_S);
      chk("R", R, m_R);
      chk("busy", BUSY, m_phase != 0);
      chk("done", DONE, m_phase == 2);
      if (m_phase != 0) chk("grant_id", GRANT_ID, m_id);
      chk("s_and_r_zero", S & R, 0);
      chk("ready_onehot0", $onehot0(REQ_READY), 1);
   endtask

   // Advance the model across the rising edge using the applied inputs.
   task automatic adv();
      int w, ix;
      logic [1:0] op;
      logic [7:0] oh;
      @(posedge CLK);
      if (RST) m_reset();
      else case (m_phase)
         0: begin
            if (CLR_ALL) begin
               m_S = 0; m_R = 8'hFF; m_id = 0; m_phase = 1;
            end else begin
               w = pick(REQ_VALID, m_ptr);
               if (w >= 0) begin
                  op = REQ_OP[2*w +: 2];
                  ix = int'(REQ_IDX[3*w +: 3]);
                  oh = 8'h01 << ix;
                  m_S = 0; m_R = 0;
                  if (op == 2'b01) m_S = oh;
                  else if (op == 2'b10) m_R = oh;
                  else if (op == 2'b11) begin
                     if (Q[ix]) m_R = oh; else m_S = oh;
                  end
                  m_id = w; m_ptr = (w + 1) % 4; m_phase = 1;
               end
            end
         end
         1: begin m_S = 0; m_R = 0; m_phase = 2; end
         default: m_phase = 0;
      endcase
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic rst, clr;
      logic [3:0] v;
      logic [7:0] op;
      logic [11:0] idx;
      logic [7:0] q;
      logic [3:0] rdy;
      logic [7:0] s, r;
      logic busy, done;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic rst, input logic clr, input logic [3:0] v, input logic [7:0] op,
                      input logic [11:0] idx, input logic [7:0] q, input logic [3:0] rdy,
                      input logic [7:0] s, input logic [7:0] r, input logic busy, input logic done);
      vec_t e;
      e.rst = rst; e.clr = clr; e.v = v; e.op = op; e.idx = idx; e.q = q;
      e.rdy = rdy; e.s = s; e.r = r; e.busy = busy; e.done = done;
      tbl.push_back(e);
   endtask

   localparam logic [7:0]  OPA = 8'h10, OPB = 8'h55, OPC = 8'h0C, OPD = 8'h0D;
   localparam logic [11:0] IXA = 12'h140, IXB = 12'h688, IXC = 12'h018;

   logic [3:0]  pv;
   logic [7:0]  pop;
   logic [11:0] pidx;
   logic [3:0]  one4;
   logic [7:0]  one8;

   initial begin
      RST = 1; CLR_ALL = 0; REQ_VALID = 0; REQ_OP = 0; REQ_IDX = 0; Q = 0;
      v6 = 0; op6 = 0; idx6 = 0; v6_n = 0; op6_n = 0; idx6_n = 0;
      m_reset();
      repeat (2) @(posedge CLK);

      // rst clr v op idx q | rdy S R busy done
      add(1,0,4'h0,0,0,0,       4'h0,8'h00,8'h00,0,0);
      add(0,0,4'h4,OPA,IXA,0,   4'h4,8'h00,8'h00,0,0);  // req2 set idx5
      add(0,0,4'h0,OPA,IXA,0,   4'h0,8'h20,8'h00,1,0);
      add(0,0,4'h0,OPA,IXA,0,   4'h0,8'h00,8'h00,1,1);
      add(1,0,4'h0,0,0,0,       4'h0,8'h00,8'h00,0,0);
      one4 = 4'h1; one8 = 8'h01;
      for (int k = 0; k < 5; k++) begin                  // all valid: 0,1,2,3,0
         add(0,0,4'hF,OPB,IXB,0, one4 << (k % 4),8'h00,8'h00,0,0);
         add(0,0,4'hF,OPB,IXB,0, 4'h0,one8 << (k % 4),8'h00,1,0);
         add(0,0,4'hF,OPB,IXB,0, 4'h0,8'h00,8'h00,1,1);
      end
      add(0,0,4'h0,OPB,IXB,0,   4'h0,8'h00,8'h00,0,0);
      add(0,0,4'h2,OPC,IXC,8'h08, 4'h2,8'h00,8'h00,0,0);  // toggle, Q[3]=1
      add(0,0,4'h0,OPC,IXC,8'h08, 4'h0,8'h00,8'h08,1,0);
      add(0,0,4'h0,OPC,IXC,8'h08, 4'h0,8'h00,8'h00,1,1);
      add(0,0,4'h2,OPC,IXC,8'h00, 4'h2,8'h00,8'h00,0,0);  // toggle, Q[3]=0
      add(0,0,4'h0,OPC,IXC,8'h00, 4'h0,8'h08,8'h00,1,0);
      add(0,0,4'h0,OPC,IXC,8'h00, 4'h0,8'h00,8'h00,1,1);
      add(0,1,4'h2,OPC,IXC,8'h00, 4'h0,8'h00,8'h00,0,0);  // clear beats req1
      add(0,0,4'h2,OPC,IXC,8'h00, 4'h0,8'h00,8'hFF,1,0);
      add(0,0,4'h2,OPC,IXC,8'h00, 4'h0,8'h00,8'h00,1,1);
      add(0,0,4'h2,OPC,IXC,8'h00, 4'h2,8'h00,8'h00,0,0);  // req1 now granted
      add(0,0,4'h0,OPC,IXC,8'h00, 4'h0,8'h08,8'h00,1,0);
      add(0,0,4'h0,OPC,IXC,8'h00, 4'h0,8'h00,8'h00,1,1);
      add(0,0,4'h0,OPD,IXC,0,   4'h0,8'h00,8'h00,0,0);
      add(0,0,4'h1,OPD,IXC,0,   4'h1,8'h00,8'h00,0,0);  // req0 set idx0
      add(1,0,4'h0,OPD,IXC,0,   4'h0,8'h01,8'h00,1,0);  // reset in ISSUE
      add(0,0,4'h9,OPD,IXC,0,   4'h1,8'h00,8'h00,0,0);  // aborted, PTR back to 0
      add(0,0,4'h0,OPD,IXC,0,   4'h0,8'h01,8'h00,1,0);
      add(0,0,4'h0,OPD,IXC,0,   4'h0,8'h00,8'h00,1,1);
      add(0,0,4'h4,OPD,IXC,0,   4'h4,8'h00,8'h00,0,0);  // req2 nop, PTR->3
      add(0,0,4'h0,OPD,IXC,0,   4'h0,8'h00,8'h00,1,0);
      add(0,0,4'h0,OPD,IXC,0,   4'h0,8'h00,8'h00,1,1);
      add(0,0,4'h1,OPD,IXC,0,   4'h1,8'h00,8'h00,0,0);  // wrap to req0, PTR->1
      add(0,0,4'h0,OPD,IXC,0,   4'h0,8'h01,8'h00,1,0);
      add(0,0,4'h0,OPD,IXC,0,   4'h0,8'h00,8'h00,1,1);
      add(0,0,4'h5,OPD,IXC,0,   4'h4,8'h00,8'h00,0,0);  // PTR=1 -> req2
      add(0,0,4'h0,OPD,IXC,0,   4'h0,8'h00,8'h00,1,0);
      add(0,0,4'h0,OPD,IXC,0,   4'h0,8'h00,8'h00,1,1);
      add(0,0,4'h0,OPD,IXC,0,   4'h0,8'h00,8'h00,0,0);

      foreach (tbl[i]) begin
         drive_chk(tbl[i].rst, tbl[i].clr, tbl[i].v, tbl[i].op, tbl[i].idx, tbl[i].q);
         chk($sformatf("tbl%0d_ready", i), REQ_READY, tbl[i].rdy);
         chk($sformatf("tbl%0d_S", i), S, tbl[i].s);
         chk($sformatf("tbl%0d_R", i), R, tbl[i].r);
         chk($sformatf("tbl%0d_busy", i), BUSY, tbl[i].busy);
         chk($sformatf("tbl%0d_done", i), DONE, tbl[i].done);
         adv();
      end

      // 6-bit bank: idx7 is out of range -> accepted as nop, DONE still pulses
      v6_n = 4'h1; op6_n = 8'h01; idx6_n = 12'h007;
      drive_chk(0,0,0,0,0,0); chk("oor_ready", rdy6, 4'h1); adv();
      v6_n = 4'h0;
      drive_chk(0,0,0,0,0,0); chk("oor_S", S6, 0); chk("oor_R", R6, 0); chk("oor_busy", busy6, 1); adv();
      drive_chk(0,0,0,0,0,0); chk("oor_done", done6, 1); adv();
      v6_n = 4'h1; idx6_n = 12'h005;
      drive_chk(0,0,0,0,0,0); chk("b6_ready", rdy6, 4'h1); adv();
      v6_n = 4'h0;
      drive_chk(0,0,0,0,0,0); chk("b6_S", S6, 6'h20); chk("b6_R", R6, 0); adv();
      drive_chk(0,0,0,0,0,0); chk("b6_done", done6, 1); adv();

      // random traffic; a requester holds its request until granted
      pv = 0; pop = 0; pidx = 0;
      for (int c = 0; c < 800; c++) begin
         for (int i = 0; i < 4; i++)
            if (!pv[i] && $urandom_range(0, 2) == 0) begin
               pv[i] = 1'b1;
               pop[2*i +: 2]  = 2'($urandom_range(0, 3));
               pidx[3*i +: 3] = 3'($urandom_range(0, 7));
            end
         drive_chk($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0,
                   pv, pop, pidx, 8'($urandom));
         pv = pv & ~m_rdy;
         adv();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
